com_bus_arbiter: RTL
====================

// Module: com_bus_arbiter
// PURPOSE
//  Sole arbiter for the shared MESI common bus (Address_Com/Data_Bus_Com/BusRd/BusRdX/Invalidate).
//  Round-robin over NUM_PROC processor-side cache requesters.
//  While a processor owns the bus, grants a secondary data-driver slot:
//  snooping caches (cache-to-cache transfer) first, then lower-level memory.
//  Sits beside cache_wrapper instances; drives the Com_Bus_Gnt_* and Mem_snoop_gnt nets of globalInterface.
// PARAMETERS
//  NUM_PROC   8     processor-side requesters (Com_Bus_Req_proc_*)
//  NUM_SNOOP  5     snoop-side requesters (Com_Bus_Req_snoop_*)
//  MAX_HOLD   1024  primary-ownership cycles before arb_timeout sets; must be >=2
// PORTS
//  clk                clk    in   1          bus clock, rising edge
//  rst                rst    in   1          async, active-high reset
//  Com_Bus_Req_proc   in   NUM_PROC   processor bus requests, level, held for whole transaction
//  Com_Bus_Req_snoop  in   NUM_SNOOP  snoop data-drive requests, level
//  Mem_snoop_req      in   1          memory requests to drive Data_Bus_Com
//  Com_Bus_Gnt_proc   out  NUM_PROC   one-hot/zero primary grant
//  Com_Bus_Gnt_snoop  out  NUM_SNOOP  one-hot/zero snoop grant
//  Com_Bus_Gnt_snoop_any out 1        OR of Com_Bus_Gnt_snoop; drives the scalar Com_Bus_Gnt_snoop net
//  Mem_snoop_gnt      out  1          memory data-drive grant
//  arb_timeout        out  1          sticky: owner exceeded MAX_HOLD; cleared only by rst
// BEHAVIOUR
//  Reset (async): all grant outputs 0; arb_timeout 0; state IDLE; rr_ptr 0; hold_cnt 0.
//  All outputs are registered; all grant decisions take effect at the next clk edge.
//  States IDLE, OWN, OWN_SNP, OWN_MEM.
//  IDLE:
//   - If any proc req: pick first requester at or after rr_ptr, with wrap.
//   - Set Com_Bus_Gnt_proc[w] and enter OWN. Latency: req sampled at edge N, gnt high after edge N+1.
//   - Snoop and mem reqs in IDLE are ignored; no grant is issued.
//  OWN:
//   - Primary grant holds while Com_Bus_Req_proc[w]=1.
//   - Any snoop req: grant lowest-index requester, enter OWN_SNP.
//   - Otherwise, Mem_snoop_req: grant memory, enter OWN_MEM.
//   - Snoop beats mem when both arrive in the same cycle.
//  OWN_SNP / OWN_MEM:
//   - Secondary grant holds while its req stays high; no preemption, including snoop preempting mem.
//   - Req drop: secondary grant is 0 at the next edge, and the state returns to OWN.
//   - A new secondary grant is possible one cycle later (1-cycle turnaround).
//  Primary release, from any OWN* state, when Com_Bus_Req_proc[w]=0:
//   - All grants go to 0 at the next edge; state returns to IDLE; rr_ptr = (w+1) mod NUM_PROC.
//   - IDLE lasts at least 1 cycle (bus turnaround), so back-to-back owners are separated by one idle cycle.
//  Req drop of an unselected requester: no effect. Two reqs never produce two grants; the grant vectors are always one-hot or zero.
//  hold_cnt:
//   - Clears on entry to OWN from IDLE and increments each cycle in OWN*.
//   - Saturates at MAX_HOLD.
//   - Reaching MAX_HOLD sets arb_timeout; the grant is NOT revoked.
//   - Width $clog2(MAX_HOLD+1).
//  rr_ptr width $clog2(NUM_PROC); wrap NUM_PROC-1 -> 0.
//  Reset mid-transaction: grants drop immediately (async), no completion.
// STRUCTURE
//  Package com_bus_arb_pkg:
//   - typedef enum logic [1:0] arb_state_t {IDLE, OWN, OWN_SNP, OWN_MEM}
//   - default NUM_PROC/NUM_SNOOP/MAX_HOLD localparams
//  Sub-module rr_picker #(N):
//   - Combinational round-robin select.
//   - Inputs req[N-1:0] and ptr; outputs onehot[N-1:0], idx, valid.
//   - Uses the double-width masked priority encode.
//  Snoop selection is a plain fixed-priority encode, inline.
// TESTING
//  1 Reset: assert rst with all reqs high -> all gnts 0, arb_timeout 0; after release, first grant is proc 0.
//  2 Single owner:
//     - Req_proc=8'h08 at edge 0 -> Gnt_proc=8'h08 after edge 1.
//     - Drop req at edge 5 -> Gnt_proc=0 after edge 6.
//     - rr_ptr=4.
//  3 Fairness: Req_proc=8'hFF held -> owners 0,1,2..7,0, each owner dropping req 3 cycles after grant; one idle cycle between owners.
//  4 Secondary:
//     - Proc 2 owns; Req_snoop=5'b00110 and Mem_snoop_req=1 in the same cycle -> Gnt_snoop=5'b00010.
//     - After drop: 5'b00100.
//     - After drop: Mem_snoop_gnt=1; Gnt_snoop_any tracks.
//  5 Ignore and abort:
//     - Snoop/mem req in IDLE -> no grant.
//     - Proc drops req while OWN_SNP -> proc and snoop gnts both 0 at the next edge.
//  6 Timeout and reset:
//     - MAX_HOLD=4, owner holds 10 cycles -> arb_timeout=1 at cycle 4 and stays set; grant is kept.
//     - Async rst mid-OWN_MEM -> Mem_snoop_gnt falls without a clk edge.

Source files
------------

// File: rtl/com_bus_arb_pkg.sv
// Shared types and default sizing for the MESI common-bus arbiter.
package com_bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      OWN_SNP = 2'd2,
      OWN_MEM = 2'd3
   } arb_state_t;

   localparam int DEF_NUM_PROC  = 8;
   localparam int DEF_NUM_SNOOP = 5;
   localparam int DEF_MAX_HOLD  = 1024;

endpackage

// File: rtl/com_bus_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
module rr_picker #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   localparam logic [IW:0] N_W = (IW+1)'(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW:0]    sum;
   logic           found;

   // Rotating the doubled vector right by ptr puts ptr at bit 0, so the
   // lowest set bit of the low half is the next requester in RR order.
   always_comb begin
      dbl    = {req, req} >> ptr;
      rot    = dbl[N-1:0];
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      onehot = '0;
      for (int j = 0; j < N; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (IW+1)'(j);
         end
      end
      if (sum >= N_W) sum = sum - N_W;
      idx   = sum[IW-1:0];
      valid = found;
      if (found) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin primary ownership for processor caches plus
// a secondary data-drive slot (snoop caches first, then memory) under an owner.
module com_bus_arbiter
   import com_bus_arb_pkg::*;
#(
   parameter int NUM_PROC  = DEF_NUM_PROC,
   parameter int NUM_SNOOP = DEF_NUM_SNOOP,
   parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
   input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
   input  logic                 Mem_snoop_req,
   output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
   output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
   output logic                 Com_Bus_Gnt_snoop_any,
   output logic                 Mem_snoop_gnt,
   output logic                 arb_timeout
);

   localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PROC - 1);

   arb_state_t           state_q;
   logic [PW-1:0]        rr_ptr_q;
   logic [PW-1:0]        owner_q;
   logic [HW-1:0]        hold_cnt_q;
   logic [HW-1:0]        hold_cnt_d;
   logic [NUM_PROC-1:0]  gnt_proc_q;
   logic [NUM_SNOOP-1:0] gnt_snoop_q;
   logic                 gnt_snoop_any_q;
   logic                 mem_gnt_q;
   logic                 timeout_q;

   logic [NUM_PROC-1:0]  pick_onehot;
   logic [PW-1:0]        pick_idx;
   logic                 pick_valid;
   logic [NUM_SNOOP-1:0] snp_onehot;
   logic                 snp_valid;
   logic                 own_req;
   logic                 snp_hold;
   logic                 timeout_hit;

   rr_picker #(
      .N  (NUM_PROC),
      .IW (PW)
   ) u_rr_picker (
      .req    (Com_Bus_Req_proc),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // Snoop slot is fixed priority: isolate the lowest set request bit.
   assign snp_onehot = Com_Bus_Req_snoop & (~Com_Bus_Req_snoop + 1'b1);
   assign snp_valid  = |Com_Bus_Req_snoop;

   assign own_req  = |(Com_Bus_Req_proc & gnt_proc_q);
   assign snp_hold = |(Com_Bus_Req_snoop & gnt_snoop_q);

   assign hold_cnt_d  = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
   assign timeout_hit = (state_q != IDLE) && (hold_cnt_d == HOLD_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         rr_ptr_q        <= '0;
         owner_q         <= '0;
         hold_cnt_q      <= '0;
         gnt_proc_q      <= '0;
         gnt_snoop_q     <= '0;
         gnt_snoop_any_q <= 1'b0;
         mem_gnt_q       <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         if (timeout_hit) timeout_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q    <= OWN;
                  owner_q    <= pick_idx;
                  gnt_proc_q <= pick_onehot;
                  hold_cnt_q <= '0;
               end
            end
            default: begin
               hold_cnt_q <= hold_cnt_d;
               if (!own_req) begin
                  // Owner release aborts any secondary transfer in flight.
                  state_q         <= IDLE;
                  gnt_proc_q      <= '0;
                  gnt_snoop_q     <= '0;
                  gnt_snoop_any_q <= 1'b0;
                  mem_gnt_q       <= 1'b0;
                  rr_ptr_q        <= (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
               end else begin
                  case (state_q)
                     OWN: begin
                        if (snp_valid) begin
                           state_q         <= OWN_SNP;
                           gnt_snoop_q     <= snp_onehot;
                           gnt_snoop_any_q <= 1'b1;
                        end else if (Mem_snoop_req) begin
                           state_q   <= OWN_MEM;
                           mem_gnt_q <= 1'b1;
                        end
                     end
                     OWN_SNP: begin
                        if (!snp_hold) begin
                           state_q         <= OWN;
                           gnt_snoop_q     <= '0;
                           gnt_snoop_any_q <= 1'b0;
                        end
                     end
                     OWN_MEM: begin
                        if (!Mem_snoop_req) begin
                           state_q   <= OWN;
                           mem_gnt_q <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign Com_Bus_Gnt_proc      = gnt_proc_q;
   assign Com_Bus_Gnt_snoop     = gnt_snoop_q;
   assign Com_Bus_Gnt_snoop_any = gnt_snoop_any_q;
   assign Mem_snoop_gnt         = mem_gnt_q;
   assign arb_timeout           = timeout_q;

endmodule
